telemetry_frame_scheduler: RTL

Packetizing round-robin scheduler that shares the single UART transmit path between several telemetry sources. It grants one source at a time and frames that source's payload as SYNC, ID, LEN, payload, CHK. It writes the frame byte-by-byte into the TX FIFO that feeds the UART transmitter, honouring FIFO backpressure. It sits between the sensor/telemetry producers and the TX FIFO write port.

---
 rtl/telemetry_pkg.sv | 21 ++
 rtl/telemetry_frame_scheduler_if.sv | 28 ++
 rtl/telemetry_frame_scheduler_rr_arbiter.sv | 34 +++
 rtl/telemetry_frame_scheduler.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/telemetry_pkg.sv
// Shared definitions for the telemetry frame scheduler: sync byte, frame FSM
// states and the running checksum helper.
package telemetry_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_ID      = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CHK     = 3'd5
    } frame_state_t;

    // Checksum is a plain modulo-256 byte sum.
    function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/telemetry_frame_scheduler_if.sv
// Source-side and TX-FIFO-side signals of the telemetry frame scheduler.
interface telemetry_frame_scheduler_if #(
    parameter int NUM_SRC = 4
);

    // Handshake: a byte is transferred on every cycle with fifo_wr_en=1, and the
    // scheduler only raises fifo_wr_en when fifo_full=0 in that same cycle.
    // src_pop[i]=1 marks the cycle in which source i's src_data byte is taken;
    // the source must present its next byte on the following cycle.
    logic [NUM_SRC-1:0]   src_req;
    logic [NUM_SRC*8-1:0] src_len;
    logic [NUM_SRC*8-1:0] src_data;
    logic [NUM_SRC-1:0]   src_pop;
    logic                 fifo_full;
    logic                 fifo_wr_en;
    logic [7:0]           fifo_wr_data;

    modport master (
        input  src_req, src_len, src_data, fifo_full,
        output src_pop, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        output src_req, src_len, src_data, fifo_full,
        input  src_pop, fifo_wr_en, fifo_wr_data
    );

endinterface

// File: rtl/telemetry_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_grant+1, wrapping.
module rr_arbiter #(
    parameter  int NUM_SRC = 4,
    localparam int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_SRC-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               pick_valid
);
    import telemetry_pkg::*;

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int off = 1; off <= NUM_SRC; off++) begin
            cand     = (int'(last_grant) + off) % NUM_SRC;
            cand_idx = IDX_W'(cand);
            if (!pick_valid && req[cand_idx]) begin
                pick_valid     = 1'b1;
                pick[cand_idx] = 1'b1;
                pick_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/telemetry_frame_scheduler.sv
// Round-robin telemetry packetizer: frames one granted source as
// SYNC, ID, LEN, payload, CHK into the UART TX FIFO under backpressure.
module telemetry_frame_scheduler #(
    parameter int         NUM_SRC   = 4,
    parameter int         MAX_LEN   = 16,
    parameter logic [7:0] SYNC_BYTE = telemetry_pkg::SYNC_BYTE
) (
    input  logic                          clk,
    input  logic                          rst,
    telemetry_frame_scheduler_if.master   bus,
    output logic [NUM_SRC-1:0]            grant,
    output logic                          frame_done,
    output logic                          busy,
    output telemetry_pkg::frame_state_t   dbg_state
);
    import telemetry_pkg::*;

    localparam int         IDX_W     = $clog2(NUM_SRC);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    frame_state_t       state_q, state_d;
    logic [IDX_W-1:0]   cur_id_q, cur_id_d;
    logic [7:0]         cur_len_q, cur_len_d;
    logic [7:0]         byte_cnt_q, byte_cnt_d;
    logic [7:0]         chk_q, chk_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;

    logic [NUM_SRC-1:0] arb_pick;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               write_ok;
    logic [7:0]         len_arr  [NUM_SRC];
    logic [7:0]         data_arr [NUM_SRC];
    logic [7:0]         req_len;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slice
        assign len_arr[i]  = bus.src_len[8*i +: 8];
        assign data_arr[i] = bus.src_data[8*i +: 8];
    end

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr_arbiter (
        .req        (bus.src_req),
        .last_grant (last_grant_q),
        .pick       (arb_pick),
        .pick_idx   (arb_idx),
        .pick_valid (arb_valid)
    );

    assign write_ok  = !bus.fifo_full;
    assign req_len   = (len_arr[arb_idx] > MAX_LEN_B) ? MAX_LEN_B : len_arr[arb_idx];
    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_id_q     <= '0;
            cur_len_q    <= '0;
            byte_cnt_q   <= '0;
            chk_q        <= '0;
            last_grant_q <= IDX_W'(NUM_SRC - 1);
            grant_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_id_q     <= cur_id_d;
            cur_len_q    <= cur_len_d;
            byte_cnt_q   <= byte_cnt_d;
            chk_q        <= chk_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cur_id_d         = cur_id_q;
        cur_len_d        = cur_len_q;
        byte_cnt_d       = byte_cnt_q;
        chk_d            = chk_q;
        last_grant_d     = last_grant_q;
        grant_d          = grant_q;
        bus.fifo_wr_en   = 1'b0;
        bus.fifo_wr_data = '0;
        bus.src_pop      = '0;
        frame_done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    cur_id_d   = arb_idx;
                    cur_len_d  = req_len;
                    byte_cnt_d = '0;
                    chk_d      = '0;
                    grant_d    = arb_pick;
                    state_d    = ST_SYNC;
                end
            end
            ST_SYNC: begin
                bus.fifo_wr_data = SYNC_BYTE;
                if (write_ok) begin
                    bus.fifo_wr_en = 1'b1;
                    state_d        = ST_ID;
                end
            end
            ST_ID: begin
                bus.fifo_wr_data = 8'(cur_id_q);
                if (write_ok) begin
                    bus.fifo_wr_en = 1'b1;
                    state_d        = ST_LEN;
                end
            end
            ST_LEN: begin
                bus.fifo_wr_data = cur_len_q;
                if (write_ok) begin
                    bus.fifo_wr_en = 1'b1;
                    state_d        = (cur_len_q != 8'd0) ? ST_PAYLOAD : ST_CHK;
                end
            end
            ST_PAYLOAD: begin
                bus.fifo_wr_data = data_arr[cur_id_q];
                if (write_ok) begin
                    bus.fifo_wr_en = 1'b1;
                    bus.src_pop    = grant_q;
                    byte_cnt_d     = byte_cnt_q + 8'd1;
                    if (byte_cnt_q == cur_len_q - 8'd1) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                bus.fifo_wr_data = chk_q;
                if (write_ok) begin
                    bus.fifo_wr_en = 1'b1;
                    frame_done     = 1'b1;
                    last_grant_d   = cur_id_q;
                    grant_d        = '0;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // SYNC and CHK itself stay out of the sum; everything else accepted is added.
        if (bus.fifo_wr_en && state_q != ST_SYNC && state_q != ST_CHK) begin
            chk_d = chk_add(chk_q, bus.fifo_wr_data);
        end
    end

endmodule
